// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, register IDs and the decode ID bundle.
package y86_pkg;

    localparam int DATA_W = 64;
    localparam int NREG   = 15;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] R_RSP  = 4'h4;
    localparam logic [3:0] R_NONE = 4'hF;

    typedef struct packed {
        logic [3:0] src_a;
        logic [3:0] src_b;
        logic [3:0] dst_e;
        logic [3:0] dst_m;
    } dec_ids_t;

    function automatic logic reg_valid(input logic [3:0] id);
        return id != R_NONE;
    endfunction

endpackage

// File: rtl/decode_writeback_if.sv
// Decode/write-back stage bus: fetch fields, execute/memory results, decoded IDs and read data.
interface decode_writeback_if #(
    parameter int DATA_W = 64
);
    logic [3:0]        icode;
    logic [3:0]        ifun;
    logic [3:0]        rA;
    logic [3:0]        rB;
    logic              cnd;
    logic              wb_en;
    logic [DATA_W-1:0] valE;
    logic [DATA_W-1:0] valM;
    logic [3:0]        srcA;
    logic [3:0]        srcB;
    logic [3:0]        dstE;
    logic [3:0]        dstM;
    logic [DATA_W-1:0] valA;
    logic [DATA_W-1:0] valB;
    logic [3:0]        dbg_addr;
    logic [DATA_W-1:0] dbg_data;

    // master is the upstream/surrounding logic, slave is the stage itself
    modport master (
        output icode, ifun, rA, rB, cnd, wb_en, valE, valM, dbg_addr,
        input  srcA, srcB, dstE, dstM, valA, valB, dbg_data
    );

    modport slave (
        input  icode, ifun, rA, rB, cnd, wb_en, valE, valM, dbg_addr,
        output srcA, srcB, dstE, dstM, valA, valB, dbg_data
    );
endinterface

// File: rtl/regfile.sv
// 15-entry register file: async clear, three combinational read ports, two write ports (M beats E).
module regfile
    import y86_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        addr_a,
    input  logic [3:0]        addr_b,
    input  logic [3:0]        addr_d,
    output logic [DATA_W-1:0] data_a,
    output logic [DATA_W-1:0] data_b,
    output logic [DATA_W-1:0] data_d,
    input  logic              we_e,
    input  logic [3:0]        addr_e,
    input  logic [DATA_W-1:0] data_e,
    input  logic              we_m,
    input  logic [3:0]        addr_m,
    input  logic [DATA_W-1:0] data_m
);

    logic [DATA_W-1:0] regs [0:NREG-1];

    function automatic logic [DATA_W-1:0] rd(input logic [3:0] a);
        if (!reg_valid(a)) return '0;
        return regs[a];
    endfunction

    // Reads see the pre-edge contents; there is no write-to-read bypass.
    assign data_a = rd(addr_a);
    assign data_b = rd(addr_b);
    assign data_d = rd(addr_d);

    // The M write is issued last so it overrides E when both target the same register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            if (we_e && reg_valid(addr_e)) regs[addr_e] <= data_e;
            if (we_m && reg_valid(addr_m)) regs[addr_m] <= data_m;
        end
    end

endmodule

// File: rtl/decode_writeback.sv
// Y86-64 sequential decode and write-back: register ID selection plus the architectural register file.
module decode_writeback
    import y86_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    decode_writeback_if.slave    bus
);

    dec_ids_t ids;
    logic     unused_ifun;

    // ifun only rides along for traceability; cmov conditions arrive already resolved in cnd.
    assign unused_ifun = ^bus.ifun;

    always_comb begin
        ids = '{src_a: R_NONE, src_b: R_NONE, dst_e: R_NONE, dst_m: R_NONE};
        case (bus.icode)
            I_RRMOVQ: begin
                ids.src_a = bus.rA;
                ids.dst_e = bus.cnd ? bus.rB : R_NONE;
            end
            I_IRMOVQ: ids.dst_e = bus.rB;
            I_RMMOVQ: begin
                ids.src_a = bus.rA;
                ids.src_b = bus.rB;
            end
            I_MRMOVQ: begin
                ids.src_b = bus.rB;
                ids.dst_m = bus.rA;
            end
            I_OPQ: begin
                ids.src_a = bus.rA;
                ids.src_b = bus.rB;
                ids.dst_e = bus.rB;
            end
            I_CALL: begin
                ids.src_b = R_RSP;
                ids.dst_e = R_RSP;
            end
            I_RET: begin
                ids.src_a = R_RSP;
                ids.src_b = R_RSP;
                ids.dst_e = R_RSP;
            end
            I_PUSHQ: begin
                ids.src_a = bus.rA;
                ids.src_b = R_RSP;
                ids.dst_e = R_RSP;
            end
            I_POPQ: begin
                ids.src_a = R_RSP;
                ids.src_b = R_RSP;
                ids.dst_e = R_RSP;
                ids.dst_m = bus.rA;
            end
            default: ;
        endcase
    end

    assign bus.srcA = ids.src_a;
    assign bus.srcB = ids.src_b;
    assign bus.dstE = ids.dst_e;
    assign bus.dstM = ids.dst_m;

    regfile #(.DATA_W(DATA_W)) u_regfile (
        .clk    (clk),
        .reset  (reset),
        .addr_a (ids.src_a),
        .addr_b (ids.src_b),
        .addr_d (bus.dbg_addr),
        .data_a (bus.valA),
        .data_b (bus.valB),
        .data_d (bus.dbg_data),
        .we_e   (bus.wb_en),
        .addr_e (ids.dst_e),
        .data_e (bus.valE),
        .we_m   (bus.wb_en),
        .addr_m (ids.dst_m),
        .data_m (bus.valM)
    );

endmodule

// File: tb/tb_decode_writeback.sv
// Directed bench for decode_writeback: ID selection per icode, write-back, priority, reset.
module tb_decode_writeback;
    localparam int DW = 64;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    decode_writeback_if #(.DATA_W(DW)) bus ();

    decode_writeback #(.DATA_W(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                         input logic c, input logic en,
                         input logic [DW-1:0] e, input logic [DW-1:0] m);
        bus.icode = ic;
        bus.ifun  = 4'h0;
        bus.rA    = ra;
        bus.rB    = rb;
        bus.cnd   = c;
        bus.wb_en = en;
        bus.valE  = e;
        bus.valM  = m;
        #1;
    endtask

    task automatic peek(input string tag, input logic [3:0] a, input logic [DW-1:0] exp);
        bus.dbg_addr = a;
        #1;
        chk(tag, bus.dbg_data, exp);
    endtask

    initial begin
        bus.dbg_addr = 4'hF;
        drive(4'h1, 4'hF, 4'hF, 1'b1, 1'b0, '0, '0);
        #12;
        peek("reset_r0", 4'h0, 64'h0);
        reset = 1'b0;

        // irmovq $0x1234, %rbx
        drive(4'h3, 4'hF, 4'h3, 1'b1, 1'b1, 64'h1234, 64'h0);
        chk("irm_dstE", {60'h0, bus.dstE}, 64'h3);
        chk("irm_dstM", {60'h0, bus.dstM}, 64'hF);
        chk("irm_srcA", {60'h0, bus.srcA}, 64'hF);
        step();
        peek("irm_r3", 4'h3, 64'h1234);
        drive(4'h6, 4'h3, 4'h3, 1'b1, 1'b0, 64'h0, 64'h0);
        chk("opq_valA", bus.valA, 64'h1234);
        chk("opq_valB", bus.valB, 64'h1234);
        chk("opq_dstE", {60'h0, bus.dstE}, 64'h3);

        // cmovXX not taken, then taken
        drive(4'h2, 4'h1, 4'h5, 1'b0, 1'b1, 64'h7, 64'h0);
        chk("cmov0_dstE", {60'h0, bus.dstE}, 64'hF);
        chk("cmov0_srcA", {60'h0, bus.srcA}, 64'h1);
        step();
        peek("cmov0_r5", 4'h5, 64'h0);
        drive(4'h2, 4'h1, 4'h5, 1'b1, 1'b1, 64'h7, 64'h0);
        chk("cmov1_dstE", {60'h0, bus.dstE}, 64'h5);
        step();
        peek("cmov1_r5", 4'h5, 64'h7);

        // popq %rsp with rsp preloaded
        drive(4'h3, 4'hF, 4'h4, 1'b1, 1'b1, 64'h100, 64'h0);
        step();
        drive(4'hB, 4'h4, 4'hF, 1'b1, 1'b1, 64'h108, 64'hABCD);
        chk("pop_srcA", {60'h0, bus.srcA}, 64'h4);
        chk("pop_srcB", {60'h0, bus.srcB}, 64'h4);
        chk("pop_dstE", {60'h0, bus.dstE}, 64'h4);
        chk("pop_dstM", {60'h0, bus.dstM}, 64'h4);
        chk("pop_valA", bus.valA, 64'h100);
        step();
        peek("pop_r4", 4'h4, 64'hABCD);

        // pushq and mrmovq ID selection
        drive(4'hA, 4'h3, 4'hF, 1'b1, 1'b0, 64'h0, 64'h0);
        chk("push_srcA", {60'h0, bus.srcA}, 64'h3);
        chk("push_srcB", {60'h0, bus.srcB}, 64'h4);
        chk("push_dstE", {60'h0, bus.dstE}, 64'h4);
        drive(4'h5, 4'h6, 4'h2, 1'b1, 1'b1, 64'h0, 64'h55);
        chk("mrm_srcA", {60'h0, bus.srcA}, 64'hF);
        chk("mrm_srcB", {60'h0, bus.srcB}, 64'h2);
        chk("mrm_dstM", {60'h0, bus.dstM}, 64'h6);
        chk("mrm_dstE", {60'h0, bus.dstE}, 64'hF);
        step();
        peek("mrm_r6", 4'h6, 64'h55);

        // read during write returns the old value until the edge
        drive(4'h3, 4'hF, 4'h2, 1'b1, 1'b1, 64'h5, 64'h0);
        step();
        drive(4'h3, 4'hF, 4'h2, 1'b1, 1'b1, 64'h9, 64'h0);
        peek("rdw_before", 4'h2, 64'h5);
        step();
        peek("rdw_after", 4'h2, 64'h9);

        // write-back disabled, then undefined icode
        drive(4'h6, 4'h1, 4'h1, 1'b1, 1'b0, 64'hFF, 64'h0);
        step();
        peek("wben0_r1", 4'h1, 64'h0);
        drive(4'hD, 4'h2, 4'h3, 1'b1, 1'b1, 64'hFF, 64'hEE);
        chk("inv_srcA", {60'h0, bus.srcA}, 64'hF);
        chk("inv_srcB", {60'h0, bus.srcB}, 64'hF);
        chk("inv_dstE", {60'h0, bus.dstE}, 64'hF);
        chk("inv_dstM", {60'h0, bus.dstM}, 64'hF);
        chk("inv_valA", bus.valA, 64'h0);
        chk("inv_valB", bus.valB, 64'h0);
        step();
        peek("inv_r3", 4'h3, 64'h1234);
        peek("dbg_none", 4'hF, 64'h0);

        // asynchronous reset mid-cycle
        #2;
        reset = 1'b1;
        #1;
        for (int i = 0; i < 15; i++) peek($sformatf("rst_r%0d", i), i[3:0], 64'h0);
        drive(4'h6, 4'h2, 4'h3, 1'b1, 1'b1, 64'h0, 64'h0);
        chk("rst_srcA", {60'h0, bus.srcA}, 64'h2);
        drive(4'h3, 4'hF, 4'h7, 1'b1, 1'b1, 64'h77, 64'h0);
        step();
        #2;
        reset = 1'b0;
        peek("rst_pending_r7", 4'h7, 64'h0);
        step();
        peek("post_rst_r7", 4'h7, 64'h77);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/decode_writeback.md
Name: decode_writeback

Overview:
- Y86-64 sequential decode and write-back stage, directly downstream of fetch.
- Consumes fetch outputs icode/ifun/rA/rB and selects the source and destination register IDs.
- Reads operands valA/valB combinationally from an internal 15-entry register file.
- Commits execute/memory results valE/valM into the register file on the rising clock edge.

Parameters:
- DATA_W, 64, register and data width.
- NREG, 15, number of architectural registers (IDs 0-14); ID 4'hF means "none".
- RSP_ID, 4, register ID of %rsp.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears the register file.
- icode  input  4  instruction code from fetch.
- ifun  input  4  function code from fetch (carried for traceability, unused in decode).
- rA  input  4  register A specifier from fetch.
- rB  input  4  register B specifier from fetch.
- cnd  input  1  condition result from execute; gates dstE for cmovXX.
- wb_en  input  1  write-back enable; deasserted for halt or invalid status.
- valE  input  DATA_W  ALU result to write to dstE.
- valM  input  DATA_W  memory read data to write to dstM.
- srcA  output  4  selected read-port A register ID.
- srcB  output  4  selected read-port B register ID.
- dstE  output  4  selected E write destination.
- dstM  output  4  selected M write destination.
- valA  output  DATA_W  contents of reg[srcA]; 0 when srcA = F.
- valB  output  DATA_W  contents of reg[srcB]; 0 when srcB = F.
- dbg_addr  input  4  debug read address.
- dbg_data  output  DATA_W  reg[dbg_addr]; 0 when dbg_addr = F.

Behaviour:
- Register IDs follow Y86 numbering: rax=0 … r14=14; F = none.
- srcA:
  - rA for icode 2, 4, 6, A.
  - RSP_ID for icode 9, B.
  - F otherwise.
- srcB:
  - rB for icode 4, 5, 6.
  - RSP_ID for icode 8, 9, A, B.
  - F otherwise.
- dstE:
  - For icode 2: rB when cnd=1, F when cnd=0 (rrmovq has ifun=0 and cnd=1 from execute).
  - rB for icode 3, 6.
  - RSP_ID for icode 8, 9, A, B.
  - F otherwise.
- dstM: rA for icode 5, B; F otherwise.
- Undefined icode (C-F), 0 (halt), 1 (nop), 7 (jXX): all IDs = F, no writes.
- Reads are combinational with zero latency.
- A read in the same cycle as a write to the same register returns the old value. No bypass; the new value is visible after the edge.
- Write-back happens on posedge clk when wb_en=1 and reset=0:
  - dstE != F → reg[dstE] <= valE.
  - dstM != F → reg[dstM] <= valM.
  - dstE == dstM (e.g. popq %rsp): valM wins, valE discarded.
  - Writes to ID F are ignored.
- wb_en=0: register file holds; decode outputs are still driven.
- Reset:
  - Asserting reset clears all 15 registers to 0 immediately, independent of clk.
  - valA/valB/dbg_data therefore read 0.
  - srcA/srcB/dstE/dstM remain combinational functions of the inputs.
  - Reset mid-operation aborts any pending write; the first write occurs at the first posedge after deassertion.
- No other state: the stage holds no pipeline registers. Latency is fetch-to-valA combinational, write-back 1 edge.

Decomposition:
- Shared package y86_pkg:
  - icode constants (I_HALT … I_POPQ).
  - Register ID constants (R_RSP=4, R_NONE=4'hF).
  - DATA_W.
- Sub-module regfile:
  - 15×DATA_W array with async reset.
  - Two read ports plus a debug read port.
  - Two write ports with M-over-E priority.
- The decode ID-select logic lives in decode_writeback itself.

Test Plan:
- Reset: assert reset mid-cycle after writes → dbg_data = 0 for all IDs 0-14 immediately; srcA for icode=6, rA=2 is still 2.
- irmovq: icode=3, rB=3, valE=0x1234, wb_en=1, one edge → dstE=3, dstM=F; reg[3]=0x1234. Then icode=6, rA=3, rB=3 → valA=valB=0x1234.
- cmovXX:
  - icode=2, ifun=2, rA=1, rB=5, cnd=0 → dstE=F; reg[5] unchanged after edge.
  - Same with cnd=1, valE=7 → reg[5]=7.
- popq %rsp: preload reg[4]=0x100; icode=B, rA=4, valE=0x108, valM=0xABCD → srcA=srcB=4, dstE=dstM=4; after edge reg[4]=0xABCD.
- Read-during-write: reg[2]=5; icode=3, rB=2, valE=9, and concurrently dbg_addr=2 → dbg_data=5 before edge, 9 after.
- wb_en=0 and invalid icode: icode=6, rB=1, valE=0xFF, wb_en=0 → reg[1] unchanged. icode=0xD → all IDs F; valA=valB=0.
